// File: rtl/char_display_scan.sv
// ---------------------------------------------------------------------------
// char_display_scan
//
// Scans a 40-bit word of eight 5-bit character codes (0 = blank, 1..26 =
// A..Z, 27..31 = dash) onto an 8-digit common-anode 7-segment display.
// Each digit is driven for SCAN_DIV cycles and is then followed by
// BLANK_CYCLES cycles with every digit off, which suppresses ghosting.
// The input word is latched once per frame, in the LOAD state, so a message
// that changes part-way through a frame is never shown torn.
//
// Ports:
//   clock        in   1   system clock, rising edge
//   rst          in   1   synchronous reset, active-high
//   instruction  in  40   char codes, [39:35] leftmost ... [4:0] rightmost
//   dim          in   1   (DISP_DIM_EN only) shorten the lit part of SHOW
//   an           out  8   digit enables, active-low, an[7] leftmost
//   seg          out  7   segments {g,f,e,d,c,b,a}, active-low
//   dp           out  1   decimal point, active-low, always off
//   frame_done   out  1   one-cycle pulse on the LOAD slot ending a frame
//
// Optional feature macro: DISP_DIM_EN (adds the dim input).
// Every output is registered, so it shows the FSM state one cycle late.
// ---------------------------------------------------------------------------
module char_display_scan #(
  parameter int unsigned SCAN_DIV     = 100000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic        clock,
  input  logic        rst,
  input  logic [39:0] instruction,
`ifdef DISP_DIM_EN
  input  logic        dim,
`endif
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int unsigned MAX_SB  = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
  localparam int unsigned CNT_MAX = (MAX_SB > 2) ? MAX_SB : 2;
  localparam int          CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);
  localparam bit               NO_BLANK   = (BLANK_CYCLES == 0);

  localparam logic [1:0] LOAD  = 2'd0;
  localparam logic [1:0] SHOW  = 2'd1;
  localparam logic [1:0] BLANK = 2'd2;

  logic [1:0]       state_reg, state_next;
  logic [39:0]      shadow_reg, shadow_next;
  logic [2:0]       k_reg, k_next;
  logic [CNT_W-1:0] counter_reg, counter_next;
  // Set when the FSM returns to LOAD after the last digit; distinguishes the
  // end-of-frame LOAD from the one straight after reset.
  logic             wrap_reg, wrap_next;
  logic [7:0]       an_reg, an_next;
  logic [6:0]       seg_reg, seg_next;
  logic             frame_done_reg;

  // Split the latched word into characters; chars[gi] is digit index 7-gi.
  logic [4:0] chars [8];
  for (genvar gi = 0; gi < 8; gi++) begin : g_chars
    assign chars[gi] = shadow_reg[5*gi +: 5];
  end

  // Active-high glyphs {g,f,e,d,c,b,a}.
  function automatic logic [6:0] glyph(input logic [4:0] code);
    case (code)
      5'd0:    glyph = 7'h00;
      5'd1:    glyph = 7'h77;  5'd2:  glyph = 7'h7C;  5'd3:  glyph = 7'h39;
      5'd4:    glyph = 7'h5E;  5'd5:  glyph = 7'h79;  5'd6:  glyph = 7'h71;
      5'd7:    glyph = 7'h3D;  5'd8:  glyph = 7'h76;  5'd9:  glyph = 7'h30;
      5'd10:   glyph = 7'h1E;  5'd11: glyph = 7'h75;  5'd12: glyph = 7'h38;
      5'd13:   glyph = 7'h55;  5'd14: glyph = 7'h54;  5'd15: glyph = 7'h3F;
      5'd16:   glyph = 7'h73;  5'd17: glyph = 7'h67;  5'd18: glyph = 7'h50;
      5'd19:   glyph = 7'h6D;  5'd20: glyph = 7'h78;  5'd21: glyph = 7'h3E;
      5'd22:   glyph = 7'h1C;  5'd23: glyph = 7'h6A;  5'd24: glyph = 7'h49;
      5'd25:   glyph = 7'h6E;  5'd26: glyph = 7'h5B;
      default: glyph = 7'h40;
    endcase
  endfunction

  // Whether the current SHOW cycle actually lights its digit.
  logic lit;
`ifdef DISP_DIM_EN
  localparam int unsigned DIM_Q = SCAN_DIV / 4;
  localparam logic [CNT_W:0] DIM_LEN = (CNT_W+1)'((DIM_Q < 1) ? 1 : DIM_Q);
  assign lit = !dim || ({1'b0, counter_reg} < DIM_LEN);
`else
  assign lit = 1'b1;
`endif

  // End of a digit's slot: end of BLANK, or end of SHOW when there is no BLANK.
  logic slot_end;
  assign slot_end = (state_reg == BLANK && counter_reg == BLANK_LAST) ||
                    (NO_BLANK && state_reg == SHOW && counter_reg == SHOW_LAST);

  always_comb begin
    state_next   = state_reg;
    shadow_next  = shadow_reg;
    k_next       = k_reg;
    counter_next = counter_reg;
    wrap_next    = wrap_reg;
    case (state_reg)
      LOAD: begin
        shadow_next  = instruction;
        k_next       = 3'd0;
        counter_next = '0;
        wrap_next    = 1'b0;
        state_next   = SHOW;
      end
      SHOW, BLANK: begin
        if (slot_end) begin
          counter_next = '0;
          if (k_reg == 3'd7) begin
            state_next = LOAD;
            wrap_next  = 1'b1;
          end else begin
            k_next     = k_reg + 3'd1;
            state_next = SHOW;
          end
        end else if (state_reg == SHOW && counter_reg == SHOW_LAST) begin
          counter_next = '0;
          state_next   = BLANK;
        end else begin
          counter_next = counter_reg + 1'b1;
        end
      end
      default: state_next = LOAD;
    endcase
  end

  always_comb begin
    an_next  = 8'hFF;
    seg_next = 7'h7F;
    if (state_reg == SHOW && lit) begin
      an_next  = ~(8'b1 << (3'd7 - k_reg));
      seg_next = ~glyph(chars[~k_reg]);
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_reg      <= LOAD;
      shadow_reg     <= '0;
      k_reg          <= '0;
      counter_reg    <= '0;
      wrap_reg       <= 1'b0;
      an_reg         <= 8'hFF;
      seg_reg        <= 7'h7F;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      shadow_reg     <= shadow_next;
      k_reg          <= k_next;
      counter_reg    <= counter_next;
      wrap_reg       <= wrap_next;
      an_reg         <= an_next;
      seg_reg        <= seg_next;
      frame_done_reg <= (state_reg == LOAD) && wrap_reg;
    end
  end

  assign an         = an_reg;
  assign seg        = seg_reg;
  assign dp         = 1'b1;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_char_display_scan.sv
// ---------------------------------------------------------------------------
// tb_char_display_scan
//
// Three instances with different timing (4/2, 1/0 and 8/2 cycles of
// show/blank) run side by side. A frame-position model predicts every output
// on every cycle from the frame arithmetic: position in frame -> LOAD slot,
// digit index, or show/blank phase, with the character taken from the word
// captured at that frame's LOAD.
// ---------------------------------------------------------------------------
module tb_char_display_scan;

  localparam int N = 3;

  logic        clock = 1'b0;
  logic        rst_i   [N];
  logic [39:0] instr_i [N];
`ifdef DISP_DIM_EN
  logic        dim_i   [N];
`endif
  logic [7:0]  an_o    [N];
  logic [6:0]  seg_o   [N];
  logic        dp_o    [N];
  logic        fd_o    [N];

  always #5 clock = ~clock;

  char_display_scan #(.SCAN_DIV(4), .BLANK_CYCLES(2)) dut_a (
    .clock(clock), .rst(rst_i[0]), .instruction(instr_i[0]),
`ifdef DISP_DIM_EN
    .dim(dim_i[0]),
`endif
    .an(an_o[0]), .seg(seg_o[0]), .dp(dp_o[0]), .frame_done(fd_o[0]));

  char_display_scan #(.SCAN_DIV(1), .BLANK_CYCLES(0)) dut_b (
    .clock(clock), .rst(rst_i[1]), .instruction(instr_i[1]),
`ifdef DISP_DIM_EN
    .dim(dim_i[1]),
`endif
    .an(an_o[1]), .seg(seg_o[1]), .dp(dp_o[1]), .frame_done(fd_o[1]));

  char_display_scan #(.SCAN_DIV(8), .BLANK_CYCLES(2)) dut_c (
    .clock(clock), .rst(rst_i[2]), .instruction(instr_i[2]),
`ifdef DISP_DIM_EN
    .dim(dim_i[2]),
`endif
    .an(an_o[2]), .seg(seg_o[2]), .dp(dp_o[2]), .frame_done(fd_o[2]));

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input int d, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s dut=%0d t=%0t got=%0h exp=%0h", tag, d, $time, got, exp);
    end
  endtask

  function automatic int show_len(input int d);
    case (d)
      0:       return 4;
      1:       return 1;
      default: return 8;
    endcase
  endfunction

  function automatic int blank_len(input int d);
    case (d)
      1:       return 0;
      default: return 2;
    endcase
  endfunction

  // Active-high glyphs indexed by code.
  logic [6:0] glyph_ref [32] = '{
    7'h00, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71, 7'h3D,
    7'h76, 7'h30, 7'h1E, 7'h75, 7'h38, 7'h55, 7'h54, 7'h3F,
    7'h73, 7'h67, 7'h50, 7'h6D, 7'h78, 7'h3E, 7'h1C, 7'h6A,
    7'h49, 7'h6E, 7'h5B, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

  // Model state: FSM cycle index since the last reset edge, word captured at
  // the latest LOAD, completed frame count.
  int          cyc    [N];
  logic [39:0] snap   [N];
  int          frames [N];

  task automatic model(input int d, input logic rs, input logic [39:0] ins, input logic ds);
    int s, b, per, len, p, q, k, r, dl;
    logic [7:0] e_an;
    logic [6:0] e_seg;
    logic       e_fd;
    logic [4:0] code;
    s = show_len(d); b = blank_len(d); per = s + b; len = 1 + 8 * per;
    dl = (s / 4 < 1) ? 1 : s / 4;
    e_an = 8'hFF; e_seg = 7'h7F; e_fd = 1'b0;
    if (rs) begin
      cyc[d] = 0;
    end else begin
      p = cyc[d] % len;
      if (p == 0) begin
        e_fd    = (cyc[d] >= len);
        snap[d] = ins;
      end else begin
        q = p - 1; k = q / per; r = q % per;
        if (r < s && (!ds || r < dl)) begin
          e_an[7-k] = 1'b0;
          code  = snap[d][5*(7-k) +: 5];
          e_seg = ~glyph_ref[code];
        end
      end
      cyc[d]++;
    end
    check("an", d, 32'(an_o[d]), 32'(e_an));
    check("seg", d, 32'(seg_o[d]), 32'(e_seg));
    check("dp", d, 32'(dp_o[d]), 32'd1);
    check("frame_done", d, 32'(fd_o[d]), 32'(e_fd));
    if (e_fd) begin
      frames[d]++;
      $display("frame dut=%0d n=%0d word=%010h t=%0t", d, frames[d], snap[d], $time);
    end
  endtask

  // One clock: sample what the DUTs see at the edge, compare #1 later, and
  // return at the falling edge so the caller drives the next inputs there.
  task automatic step();
    logic        rs [N];
    logic [39:0] is [N];
    logic        ds [N];
    @(posedge clock);
    for (int d = 0; d < N; d++) begin
      rs[d] = rst_i[d];
      is[d] = instr_i[d];
`ifdef DISP_DIM_EN
      ds[d] = dim_i[d];
`else
      ds[d] = 1'b0;
`endif
    end
    #1;
    for (int d = 0; d < N; d++) model(d, rs[d], is[d], ds[d]);
    @(negedge clock);
  endtask

  function automatic logic [39:0] rand40();
    return {8'($urandom), 32'($urandom)};
  endfunction

  logic [39:0] withdraw;
  logic [39:0] codes;

  initial begin
    withdraw = {5'd23, 5'd9, 5'd20, 5'd8, 5'd4, 5'd18, 5'd1, 5'd23};
    codes    = {5'd0, 5'd27, 5'd28, 5'd29, 5'd30, 5'd31, 5'd26, 5'd1};
    for (int d = 0; d < N; d++) begin
      rst_i[d]   = 1'b1;
      instr_i[d] = rand40();
`ifdef DISP_DIM_EN
      dim_i[d]   = 1'b0;
`endif
      cyc[d]     = 0;
      snap[d]    = '0;
      frames[d]  = 0;
    end

    // Reset held for three edges with arbitrary input.
    repeat (3) step();
    for (int d = 0; d < N; d++) rst_i[d] = 1'b0;
    instr_i[0] = withdraw;
    instr_i[1] = rand40();
    instr_i[2] = withdraw;
    repeat (2 * 49 + 5) step();

    // Change the word while digit 3 is on screen; the frame must not tear.
    for (int i = 0; i < 49 && (cyc[0] % 49) != 21; i++) step();
    instr_i[0] = '0;
    repeat (2 * 49) step();

    instr_i[0] = codes;
    repeat (2 * 49 + 3) step();

    // Reset the 1/0 instance in the middle of digit 5.
    for (int i = 0; i < 9 && (cyc[1] % 9) != 6; i++) step();
    rst_i[1] = 1'b1;
    step();
    rst_i[1] = 1'b0;
    repeat (20) step();

`ifdef DISP_DIM_EN
    dim_i[2] = 1'b1;
    repeat (2 * 81) step();
    dim_i[2] = 1'b0;
`endif
    repeat (2 * 81) step();

    // Random phase: word changes at arbitrary times, rare resets, random dim.
    repeat (1500) begin
      for (int d = 0; d < N; d++) begin
        if ($urandom_range(0, 19) == 0) instr_i[d] = rand40();
        rst_i[d] = ($urandom_range(0, 399) == 0);
`ifdef DISP_DIM_EN
        if ($urandom_range(0, 99) == 0) dim_i[d] = ~dim_i[d];
`endif
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
